// File: rtl/spi_flash_resp.sv
// rtl/spi_flash_resp.sv - SPI mode-0 flash responder: READ (0x03) streaming from a memory port.
// Optional JEDEC ID (0x9F) answer when SPI_FLASH_RESP_ID_EN is defined.
module spi_flash_resp #(
    parameter logic [7:0] READ_CMD = 8'h03
`ifdef SPI_FLASH_RESP_ID_EN
    ,
    parameter logic [7:0]  ID_CMD   = 8'h9F,
    parameter logic [23:0] JEDEC_ID = 24'hEF4018
`endif
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        spi_clk,
    input  logic        spi_mosi,
    input  logic        spi_cs,
    output logic        spi_miso,
    output logic [23:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    output logic        cmd_strobe,
    output logic [7:0]  cmd_byte,
    output logic        busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CMD    = 3'd1;
    localparam logic [2:0] S_ADDR   = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_IGNORE = 3'd4;

    logic [1:0]  sclk_sync;
    logic        sclk_q;
    logic [1:0]  mosi_sync;
    logic [1:0]  cs_sync;
    logic        cs_q;
    logic        sclk_rise;
    logic        sclk_fall;
    logic        cs_rise;
    logic        mosi_s;
    logic        cs_s;

    logic [2:0]  state;
    logic [4:0]  bit_cnt;
    logic [22:0] rx_shift;
    logic [23:0] rx_next;
    logic [7:0]  tx_shift;
    logic        load_pending;
`ifdef SPI_FLASH_RESP_ID_EN
    logic        id_mode;
    logic [1:0]  id_idx;
`endif

    assign mosi_s    = mosi_sync[1];
    assign cs_s      = cs_sync[1];
    assign sclk_rise = sclk_sync[1] & ~sclk_q;
    assign sclk_fall = ~sclk_sync[1] & sclk_q;
    assign cs_rise   = cs_s & ~cs_q;
    assign rx_next   = {rx_shift, mosi_s};

    // cs synchronizer resets to deasserted so busy stays low out of reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync <= 2'b00;
            sclk_q    <= 1'b0;
            mosi_sync <= 2'b00;
            cs_sync   <= 2'b11;
            cs_q      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[0], spi_clk};
            sclk_q    <= sclk_sync[1];
            mosi_sync <= {mosi_sync[0], spi_mosi};
            cs_sync   <= {cs_sync[0], spi_cs};
            cs_q      <= cs_sync[1];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            bit_cnt      <= 5'd0;
            rx_shift     <= 23'd0;
            tx_shift     <= 8'd0;
            load_pending <= 1'b0;
            spi_miso     <= 1'b0;
            mem_addr     <= 24'd0;
            mem_rd       <= 1'b0;
            cmd_strobe   <= 1'b0;
            cmd_byte     <= 8'd0;
            busy         <= 1'b0;
`ifdef SPI_FLASH_RESP_ID_EN
            id_mode      <= 1'b0;
            id_idx       <= 2'd0;
`endif
        end else begin
            mem_rd       <= 1'b0;
            cmd_strobe   <= 1'b0;
            load_pending <= mem_rd;
            busy         <= ~cs_q;
            if (cs_rise) begin
                // end of transaction wins over any clock edge; a pending fetch is dropped
                state        <= S_IDLE;
                spi_miso     <= 1'b0;
                bit_cnt      <= 5'd0;
                rx_shift     <= 23'd0;
                tx_shift     <= 8'd0;
                load_pending <= 1'b0;
`ifdef SPI_FLASH_RESP_ID_EN
                id_mode      <= 1'b0;
                id_idx       <= 2'd0;
`endif
            end else begin
                if (load_pending) tx_shift <= mem_rdata;
                if (sclk_rise) rx_shift <= rx_next[22:0];
                case (state)
                    S_IDLE: begin
                        if (!cs_s) begin
                            state   <= S_CMD;
                            bit_cnt <= 5'd0;
                        end
                    end
                    S_CMD: begin
                        if (sclk_rise) begin
                            if (bit_cnt == 5'd7) begin
                                bit_cnt    <= 5'd0;
                                cmd_byte   <= rx_next[7:0];
                                cmd_strobe <= 1'b1;
                                if (rx_next[7:0] == READ_CMD) state <= S_ADDR;
`ifdef SPI_FLASH_RESP_ID_EN
                                else if (rx_next[7:0] == ID_CMD) begin
                                    state    <= S_DATA;
                                    tx_shift <= JEDEC_ID[23:16];
                                    id_mode  <= 1'b1;
                                    id_idx   <= 2'd1;
                                end
                                else state <= S_IGNORE;
`else
                                else state <= S_IGNORE;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    S_ADDR: begin
                        if (sclk_rise) begin
                            if (bit_cnt == 5'd23) begin
                                bit_cnt  <= 5'd0;
                                mem_addr <= rx_next;
                                mem_rd   <= 1'b1;
                                state    <= S_DATA;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    S_DATA: begin
                        if (sclk_rise) begin
                            if (bit_cnt == 5'd7) begin
                                bit_cnt <= 5'd0;
`ifdef SPI_FLASH_RESP_ID_EN
                                if (id_mode) begin
                                    case (id_idx)
                                        2'd1:    tx_shift <= JEDEC_ID[15:8];
                                        2'd2:    tx_shift <= JEDEC_ID[7:0];
                                        default: tx_shift <= 8'd0;
                                    endcase
                                    if (id_idx != 2'd3) id_idx <= id_idx + 2'd1;
                                end else begin
`endif
                                mem_addr <= mem_addr + 24'd1;
                                mem_rd   <= 1'b1;
`ifdef SPI_FLASH_RESP_ID_EN
                                end
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end else if (sclk_fall) begin
                            spi_miso <= tx_shift[7];
                            tx_shift <= {tx_shift[6:0], 1'b0};
                        end
                    end
                    S_IGNORE: spi_miso <= 1'b0;
                    default:  state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_resp.sv
// tb/tb_spi_flash_resp.sv - directed bench for spi_flash_resp.
module tb_spi_flash_resp;

    localparam int HALF = 6;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        spi_clk = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        spi_cs = 1'b1;
    logic        spi_miso;
    logic [23:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata = 8'd0;
    logic        cmd_strobe;
    logic [7:0]  cmd_byte;
    logic        busy;

    int n_checks = 0;
    int n_fail = 0;
    int rd_cnt = 0;
    int strobe_cnt = 0;
    int miso_hi_cnt = 0;
    logic [23:0] rd_log [64];

    spi_flash_resp dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .spi_clk    (spi_clk),
        .spi_mosi   (spi_mosi),
        .spi_cs     (spi_cs),
        .spi_miso   (spi_miso),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_rdata  (mem_rdata),
        .cmd_strobe (cmd_strobe),
        .cmd_byte   (cmd_byte),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    // memory model: data = addr[7:0] ^ 0xA5, one clock after the strobe
    always @(posedge clock) begin
        if (mem_rd) mem_rdata <= mem_addr[7:0] ^ 8'hA5;
        if (reset_n && mem_rd) begin
            if (rd_cnt < 64) rd_log[rd_cnt] = mem_addr;
            rd_cnt = rd_cnt + 1;
        end
        if (reset_n && cmd_strobe) strobe_cnt = strobe_cnt + 1;
        if (reset_n && spi_miso) miso_hi_cnt = miso_hi_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic spi_shift(input logic [23:0] tx, input int n, output logic [23:0] rx);
        rx = 24'd0;
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clock);
            spi_mosi = tx[i];
            repeat (HALF) @(negedge clock);
            spi_clk = 1'b1;
            rx = {rx[22:0], spi_miso};
            repeat (HALF) @(negedge clock);
            spi_clk = 1'b0;
        end
    endtask

    task automatic cs_low();
        @(negedge clock);
        spi_cs = 1'b0;
        repeat (8) @(negedge clock);
    endtask

    task automatic cs_high();
        @(negedge clock);
        spi_cs = 1'b1;
        repeat (10) @(negedge clock);
    endtask

    initial begin
        logic [23:0] rx;
        int base;
        int sbase;
        int mbase;

        repeat (3) @(negedge clock);
        check_eq("rst_miso", {31'd0, spi_miso}, 32'd0);
        check_eq("rst_addr", {8'd0, mem_addr}, 32'd0);
        check_eq("rst_rd", {31'd0, mem_rd}, 32'd0);
        check_eq("rst_strobe", {31'd0, cmd_strobe}, 32'd0);
        check_eq("rst_cmd", {24'd0, cmd_byte}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);

        // READ two bytes from 0x001234
        base = rd_cnt;
        sbase = strobe_cnt;
        cs_low();
        check_eq("rd_busy", {31'd0, busy}, 32'd1);
        spi_shift(24'h000003, 8, rx);
        spi_shift(24'h001234, 24, rx);
        spi_shift(24'd0, 8, rx);
        check_eq("rd_byte0", {24'd0, rx[7:0]}, 32'h91);
        spi_shift(24'd0, 8, rx);
        check_eq("rd_byte1", {24'd0, rx[7:0]}, 32'h90);
        check_eq("rd_addr0", {8'd0, rd_log[base]}, 32'h001234);
        check_eq("rd_addr1", {8'd0, rd_log[base + 1]}, 32'h001235);
        check_eq("rd_strobes", strobe_cnt - sbase, 32'd1);
        check_eq("rd_cmd", {24'd0, cmd_byte}, 32'h03);
        cs_high();
        check_eq("rd_busy_end", {31'd0, busy}, 32'd0);
        check_eq("rd_miso_end", {31'd0, spi_miso}, 32'd0);

        // address wrap
        base = rd_cnt;
        cs_low();
        spi_shift(24'h000003, 8, rx);
        spi_shift(24'hFFFFFF, 24, rx);
        spi_shift(24'd0, 16, rx);
        check_eq("wrap_data", {16'd0, rx[15:0]}, 32'h5AA5);
        check_eq("wrap_addr0", {8'd0, rd_log[base]}, 32'hFFFFFF);
        check_eq("wrap_addr1", {8'd0, rd_log[base + 1]}, 32'h000000);
        cs_high();

        // JEDEC ID, four bytes
        base = rd_cnt;
        cs_low();
        spi_shift(24'h00009F, 8, rx);
        spi_shift(24'd0, 24, rx);
`ifdef SPI_FLASH_RESP_ID_EN
        check_eq("id_bytes", {8'd0, rx}, 32'hEF4018);
`else
        check_eq("id_bytes", {8'd0, rx}, 32'h000000);
`endif
        spi_shift(24'd0, 8, rx);
        check_eq("id_byte3", {24'd0, rx[7:0]}, 32'h00);
        check_eq("id_cmd", {24'd0, cmd_byte}, 32'h9F);
        cs_high();
        check_eq("id_no_rd", rd_cnt - base, 32'd0);

        // unknown command
        base = rd_cnt;
        mbase = miso_hi_cnt;
        cs_low();
        spi_shift(24'h000005, 8, rx);
        spi_shift(24'h00FFFF, 16, rx);
        check_eq("unk_rx", {8'd0, rx}, 32'd0);
        check_eq("unk_cmd", {24'd0, cmd_byte}, 32'h05);
        cs_high();
        check_eq("unk_no_rd", rd_cnt - base, 32'd0);
        check_eq("unk_miso", miso_hi_cnt - mbase, 32'd0);

        // cs abort after 12 address bits, then a clean read of 0x000010
        base = rd_cnt;
        cs_low();
        spi_shift(24'h000003, 8, rx);
        spi_shift(24'h000ABC, 12, rx);
        cs_high();
        check_eq("abort_no_rd", rd_cnt - base, 32'd0);
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        base = rd_cnt;
        cs_low();
        spi_shift(24'h000003, 8, rx);
        spi_shift(24'h000010, 24, rx);
        spi_shift(24'd0, 8, rx);
        check_eq("abort_data", {24'd0, rx[7:0]}, 32'hB5);
        check_eq("abort_addr", {8'd0, rd_log[base]}, 32'h000010);
        cs_high();

        // reset during the second data byte
        cs_low();
        spi_shift(24'h000003, 8, rx);
        spi_shift(24'h000020, 24, rx);
        spi_shift(24'd0, 8, rx);
        check_eq("mid_byte0", {24'd0, rx[7:0]}, 32'h85);
        spi_shift(24'd0, 4, rx);
        @(negedge clock);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        check_eq("mid_rst_miso", {31'd0, spi_miso}, 32'd0);
        check_eq("mid_rst_addr", {8'd0, mem_addr}, 32'd0);
        check_eq("mid_rst_rd", {31'd0, mem_rd}, 32'd0);
        check_eq("mid_rst_strobe", {31'd0, cmd_strobe}, 32'd0);
        check_eq("mid_rst_cmd", {24'd0, cmd_byte}, 32'd0);
        check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
        spi_cs = 1'b1;
        spi_clk = 1'b0;
        repeat (4) @(negedge clock);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);
        base = rd_cnt;
        cs_low();
        spi_shift(24'h000003, 8, rx);
        spi_shift(24'h000040, 24, rx);
        spi_shift(24'd0, 8, rx);
        check_eq("post_rst_data", {24'd0, rx[7:0]}, 32'hE5);
        check_eq("post_rst_addr", {8'd0, rd_log[base]}, 32'h000040);
        check_eq("post_rst_cmd", {24'd0, cmd_byte}, 32'h03);
        cs_high();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
